// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, occupancy encoding and per-stage payload bundles
//   PIPE_WIDTH       default payload width
//   PIPE_RESET_DATA  default reset/flush payload value
//   occ_e            occupancy encoding: OCC_EMPTY, OCC_ONE, OCC_TWO
//   ifid_t .. memwb_t  stage bundles; each stage sets WIDTH = $bits(<bundle>)
package pipe_pkg;
  localparam int PIPE_WIDTH = 32;
  localparam logic [255:0] PIPE_RESET_DATA = '0;
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;
  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc_plus4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } idex_t;
  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc_plus4;
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
  } exmem_t;
  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc_plus4;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [4:0]  rd;
  } memwb_t;
  function automatic occ_e occ_of(input logic main_v, input logic skid_v);
    return (main_v && skid_v) ? OCC_TWO : ((main_v || skid_v) ? OCC_ONE : OCC_EMPTY);
  endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: ready/valid handshake bundle around one pipeline stage register
//   in_valid/in_data/in_ready     upstream side
//   out_valid/out_data/out_ready  downstream side
//   master: the environment around the stage; slave: the stage register itself
interface pipe_stage_reg_if import pipe_pkg::*; #(
  parameter int WIDTH = PIPE_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid+data entry
//   clock, clear_n  clock and async active-low reset
//   clear           sync squash: invalid, data back to RESET_DATA (wins over load)
//   load, d         capture d and mark valid
//   drop            mark invalid, data held
//   valid, data     entry state
module pipe_skid_slot #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with handshake, flush and optional skid entry
//   clock, clear_n  clock and async active-low reset
//   bus             handshake bundle (slave side)
//   flush           sync squash of held and incoming payloads
//   stall_cnt       saturating count of out_valid && !out_ready cycles
//   occupancy       number of valid entries
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int               WIDTH      = PIPE_WIDTH,
  parameter int               SKID       = 0,
  parameter int               CNT_W      = 16,
  parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(PIPE_RESET_DATA)
) (
  input  logic             clock,
  input  logic             clear_n,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       occupancy
);
  logic             acc;
  logic             con;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             main_from_skid;
  logic             main_load;
  logic [WIDTH-1:0] main_d;
  assign acc            = bus.in_valid && bus.in_ready;
  assign con            = bus.out_valid && bus.out_ready;
  // skid mode registers the ready path: in_ready comes straight from the skid flop
  assign bus.in_ready   = (SKID != 0) ? !skid_valid : (bus.out_ready || !bus.out_valid);
  // a held skid entry always goes out before anything new, keeping FIFO order
  assign main_from_skid = skid_valid && con;
  assign main_load      = main_from_skid || (acc && (!bus.out_valid || con));
  assign main_d         = main_from_skid ? skid_data : bus.in_data;
  pipe_skid_slot #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_main (
    .clock  (clock),
    .clear_n(clear_n),
    .clear  (flush),
    .load   (main_load),
    .drop   (con),
    .d      (main_d),
    .valid  (bus.out_valid),
    .data   (bus.out_data)
  );
  if (SKID != 0) begin : g_skid
    logic skid_load;
    assign skid_load = acc && bus.out_valid && (!con || skid_valid);
    pipe_skid_slot #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_skid (
      .clock  (clock),
      .clear_n(clear_n),
      .clear  (flush),
      .load   (skid_load),
      .drop   (main_from_skid),
      .d      (bus.in_data),
      .valid  (skid_valid),
      .data   (skid_data)
    );
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_data  = RESET_DATA;
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) stall_cnt <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
  assign occupancy = occ_of(bus.out_valid, skid_valid);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for three stage configurations
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        clear_n;
  logic        iv[3];
  logic        ordy[3];
  logic        fl[3];
  logic [31:0] id[3];
  logic        irdy[3];
  logic        ovld[3];
  logic [31:0] odat[3];
  logic [31:0] stc[3];
  logic [1:0]  occ[3];
  logic [15:0] s0;
  logic [15:0] s1;
  logic [3:0]  s2;
  int sk[3]   = '{0, 1, 1};
  int cmax[3] = '{65535, 65535, 15};
  int es[3];
  logic [31:0] q[$];
  int checks = 0;
  int errors = 0;
  pipe_stage_reg_if #(.WIDTH(32)) b0 ();
  pipe_stage_reg_if #(.WIDTH(32)) b1 ();
  pipe_stage_reg_if #(.WIDTH(32)) b2 ();
  assign b0.in_valid = iv[0];
  assign b0.in_data = id[0];
  assign b0.out_ready = ordy[0];
  assign b1.in_valid = iv[1];
  assign b1.in_data = id[1];
  assign b1.out_ready = ordy[1];
  assign b2.in_valid = iv[2];
  assign b2.in_data = id[2];
  assign b2.out_ready = ordy[2];
  assign irdy[0] = b0.in_ready;
  assign irdy[1] = b1.in_ready;
  assign irdy[2] = b2.in_ready;
  assign ovld[0] = b0.out_valid;
  assign ovld[1] = b1.out_valid;
  assign ovld[2] = b2.out_valid;
  assign odat[0] = b0.out_data;
  assign odat[1] = b1.out_data;
  assign odat[2] = b2.out_data;
  assign stc[0] = 32'(s0);
  assign stc[1] = 32'(s1);
  assign stc[2] = 32'(s2);
  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) dut0 (
    .clock(clk), .clear_n(clear_n), .bus(b0), .flush(fl[0]), .stall_cnt(s0), .occupancy(occ[0])
  );
  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut1 (
    .clock(clk), .clear_n(clear_n), .bus(b1), .flush(fl[1]), .stall_cnt(s1), .occupancy(occ[1])
  );
  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(4)) dut2 (
    .clock(clk), .clear_n(clear_n), .bus(b2), .flush(fl[2]), .stall_cnt(s2), .occupancy(occ[2])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic chk_idle_reset(input int u);
    chk($sformatf("rst_in_ready%0d", u), 32'(irdy[u]), 32'd1);
    chk($sformatf("rst_out_valid%0d", u), 32'(ovld[u]), 32'd0);
    chk($sformatf("rst_out_data%0d", u), odat[u], 32'd0);
    chk($sformatf("rst_stall%0d", u), stc[u], 32'd0);
    chk($sformatf("rst_occ%0d", u), 32'(occ[u]), 32'd0);
  endtask
  task automatic step(input int u, input logic v, input logic [31:0] d, input logic r, input logic f);
    logic er;
    logic acc;
    logic [31:0] h;
    iv[u] = v;
    id[u] = d;
    ordy[u] = r;
    fl[u] = f;
    @(negedge clk);
    er = (sk[u] != 0) ? (q.size() < 2) : (r || q.size() == 0);
    chk($sformatf("in_ready%0d", u), 32'(irdy[u]), 32'(er));
    chk($sformatf("out_valid%0d", u), 32'(ovld[u]), 32'(q.size() != 0));
    acc = v && er;
    if (q.size() != 0 && !r && es[u] < cmax[u]) es[u]++;
    if (q.size() != 0 && r) begin
      h = q.pop_front();
      chk($sformatf("out_data%0d", u), odat[u], h);
    end
    @(posedge clk);
    #1;
    if (acc) q.push_back(d);
    if (f) q.delete();
    chk($sformatf("occupancy%0d", u), 32'(occ[u]), 32'(q.size()));
    chk($sformatf("stall_cnt%0d", u), stc[u], 32'(es[u]));
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
      fl[k] = 1'b0;
      id[k] = '0;
      es[k] = 0;
    end
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_idle_reset(k);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    // streaming through the skid stage
    for (int i = 1; i <= 8; i++) step(1, 1'b1, 32'(i), 1'b1, 1'b0);
    step(1, 1'b0, 32'd0, 1'b1, 1'b0);
    // backpressure: A then B into skid, C held upstream
    step(1, 1'b1, 32'hA, 1'b1, 1'b0);
    step(1, 1'b1, 32'hB, 1'b0, 1'b0);
    repeat (3) step(1, 1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_stall4", stc[1], 32'd4);
    repeat (2) step(1, 1'b1, 32'hC, 1'b1, 1'b0);
    step(1, 1'b0, 32'd0, 1'b1, 1'b0);
    // flush while two entries are held, with 0xDEAD offered
    step(1, 1'b1, 32'h11, 1'b0, 1'b0);
    step(1, 1'b1, 32'h22, 1'b0, 1'b0);
    chk("flush_occ2", 32'(occ[1]), 32'd2);
    step(1, 1'b1, 32'hDEAD, 1'b1, 1'b1);
    chk("flush_data_reset", odat[1], 32'd0);
    step(1, 1'b1, 32'hDEAD, 1'b1, 1'b1);
    repeat (2) step(1, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("flush_stall_kept", stc[1], 32'd5);
    // pass-through on a full single register, then X data held off by in_ready=0
    step(0, 1'b1, 32'h44, 1'b1, 1'b0);
    step(0, 1'b1, 32'h55, 1'b1, 1'b0);
    chk("pass_data", odat[0], 32'h55);
    chk("pass_stall", stc[0], 32'd0);
    repeat (2) step(0, 1'b1, 32'hxxxx_xxxx, 1'b0, 1'b0);
    chk("x_blocked", odat[0], 32'h55);
    step(0, 1'b0, 32'd0, 1'b1, 1'b0);
    // asynchronous reset in the middle of a held transfer
    step(0, 1'b1, 32'h77, 1'b0, 1'b0);
    step(0, 1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    clear_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(ovld[0]), 32'd0);
    chk("async_out_data", odat[0], 32'd0);
    chk("async_stall0", stc[0], 32'd0);
    chk("async_stall1", stc[1], 32'd0);
    chk("async_occ", 32'(occ[0]), 32'd0);
    q.delete();
    for (int k = 0; k < 3; k++) es[k] = 0;
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready0", 32'(irdy[0]), 32'd1);
    chk("post_rst_ready1", 32'(irdy[1]), 32'd1);
    step(0, 1'b0, 32'd0, 1'b1, 1'b0);
    // 4-bit stall counter saturation
    step(2, 1'b1, 32'h99, 1'b0, 1'b0);
    repeat (20) step(2, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("sat15", stc[2], 32'd15);
    repeat (2) step(2, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("sat_hold", stc[2], 32'd15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries a WIDTH-bit payload bundle (instruction, PC+4, control bits, data) with a valid bit and a ready/valid handshake, so a stage can be stalled. It supports a synchronous flush for branch/jump squash and an optional 2-entry skid buffer that registers the ready path. A saturating stall counter is included for performance observation.

Parameters:
WIDTH, 32, payload width in bits (1..256)
SKID, 0, 0 = single register with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready
CNT_W, 16, width of the stall-cycle counter
RESET_DATA, 0, value loaded into payload registers on reset and on flush

Ports:
clock  in  1  stage clock, rising edge
clear_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream stage has a payload
in_data  in  WIDTH  upstream payload
in_ready  out  1  this stage accepts in_data this cycle
out_valid  out  1  payload presented downstream
out_data  out  WIDTH  payload to next stage
out_ready  in  1  downstream accepts out_data
flush  in  1  squash all held and incoming payloads (branch/jump taken)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
occupancy  out  2  entries held: 0..1 when SKID=0, 0..2 when SKID=1

Behaviour:
- Reset (clear_n=0, async): out_valid=0; out_data=RESET_DATA; skid entry invalid and its data=RESET_DATA; stall_cnt=0; occupancy=0. in_ready is 1 after reset in both modes.
- Transfer rule: input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- SKID=0:
  - in_ready = out_ready || !out_valid (combinational).
  - On accept, out_data <= in_data and out_valid <= 1 next edge. Latency is 1 cycle.
  - If consumed with no accept, out_valid <= 0. out_data holds its last value.
- SKID=1:
  - Main register (out) plus skid register. in_ready = !skid_valid, driven from a flop.
  - Accept while out is empty, or out is consumed the same cycle: data goes to out.
  - Accept while out is full and not consumed: data goes to skid.
  - Out consumed while skid is valid: skid moves to out; skid becomes invalid unless a new input is accepted the same cycle, in which case it refills.
  - Order is strictly FIFO. Throughput is 1 per cycle with out_ready held high. Latency is 1 cycle.
- Stalled out_data is stable: out_data and out_valid do not change while out_valid && !out_ready, unless flush is asserted.
- Flush (synchronous, highest priority below reset):
  - Next edge: out_valid=0, skid invalid, occupancy=0, and all held payload registers=RESET_DATA.
  - Any input accepted in the flush cycle is discarded.
  - in_ready follows the normal formula during the flush cycle.
- stall_cnt: increments each cycle out_valid && !out_ready; saturates at 2^CNT_W-1; never wraps; cleared only by reset, not by flush.
- occupancy: equals the count of valid entries after each edge.
- Simultaneous accept and consume on a full single register (SKID=0): the pass-through is legal and occupancy stays 1.
- Reset mid-transfer: all held payloads are lost, with no partial state.
- in_valid with X data while in_ready=0: must not propagate.

Decomposition:
- Shared package pipe_pkg: default WIDTH constant; RESET_DATA default; occupancy encoding constants (OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2).
- Payload bundle typedefs for each stage also belong in pipe_pkg: ifid_t {instr, pc_plus4}, idex_t, exmem_t, memwb_t. Each stage instance sets WIDTH to $bits of its bundle.
- One natural sub-module, pipe_skid_slot: a single valid+data flop with load/clear, instantiated twice when SKID=1 and once when SKID=0.
- Stall counter logic stays inline.

Test Plan:
- Reset with WIDTH=32, SKID=0: assert clear_n=0 mid-cycle -> out_valid=0, out_data=0, stall_cnt=0 immediately (async); in_ready=1 after release.
- Streaming, SKID=1: in_valid=1 with data 0x1,0x2,…,0x8 on consecutive cycles, out_ready=1 -> out_data 0x1..0x8 one cycle later each, no bubbles, occupancy=1.
- Backpressure, SKID=1: send 0xA,0xB,0xC, hold out_ready=0 from cycle 1 for 4 cycles -> in_ready drops after 0xB is taken, 0xC is held upstream, stall_cnt=4, release gives 0xA,0xB,0xC in order.
- Flush, SKID=1: with occupancy=2, assert flush together with in_valid=1 data 0xDEAD -> next cycle out_valid=0, occupancy=0, 0xDEAD never appears, stall_cnt unchanged.
- Pass-through on a full register, SKID=0: out_valid=1, out_ready=1, in_valid=1 data 0x55 -> next cycle out_data=0x55, out_valid=1, no stall counted.
- Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
